rggen_trigger_scheduler: RTL and testbench
==========================================

# rggen_trigger_scheduler

Serialises one-cycle trigger pulses from a group of W0/W1-trigger bit fields onto a single downstream command channel. Latches each trigger as a pending request, grants pending requests round-robin, issues one command at a time over a valid/ready handshake, and waits for a completion strobe before issuing the next. Pending and overrun status feed back to register read data, so software can poll busy and lost-trigger state. Sits between a register block's trigger fields and a shared sequential engine such as a DMA kick or a calibration unit.

## Interface
- WIDTH, 4: number of trigger sources, 1..32.
- INDEX_WIDTH, localparam: max(1, $clog2(WIDTH)).
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_trigger  input  WIDTH  one-cycle trigger pulses, one bit per source.
- o_pending  output  WIDTH  latched, not-yet-accepted requests; feeds the trigger field read value.
- o_overrun  output  WIDTH  sticky flag: a trigger arrived while that source was already pending.
- i_overrun_clear  input  WIDTH  per-bit clear of o_overrun.
- o_cmd_valid  output  1  a command is offered.
- o_cmd_index  output  INDEX_WIDTH  source index of the offered command.
- i_cmd_ready  input  1  downstream accepts the command.
- i_cmd_done  input  1  downstream has finished the accepted command.
- o_busy  output  1  state is not IDLE.

## Operation
- **Reset values:** o_pending=0, o_overrun=0, o_cmd_valid=0, o_cmd_index=0, o_busy=0. State is IDLE. Round-robin pointer is WIDTH-1, so source 0 has first priority.
- **Pending:** pending[i] is set on i_trigger[i]. It is cleared on the cycle after the handshake (o_cmd_valid && i_cmd_ready) for index i. If a trigger and the handshake clear for the same bit land in the same cycle, the bit stays set: it is a new request and does not count as an overrun.
- **Overrun:** overrun[i] is set when i_trigger[i] arrives while pending[i]=1 and the bit is not being cleared that cycle. It is cleared by i_overrun_clear[i]. If set and clear coincide, set wins.
- **States:**
  - IDLE: if pending is nonzero, pick the first set bit searching from pointer+1 with wrap-around. Register the pick into o_cmd_index, assert o_cmd_valid, and go to ISSUE.
  - ISSUE: hold o_cmd_valid and o_cmd_index stable until i_cmd_ready. On the handshake, drop valid, set pointer to the granted index, and go to WAIT_DONE.
  - WAIT_DONE: on i_cmd_done, go to IDLE.
- **Ignored inputs:** i_cmd_done is ignored in IDLE and ISSUE. i_cmd_ready is ignored when o_cmd_valid=0.
- **Re-trigger during execution:** a trigger for a source whose command is in WAIT_DONE sets pending again and is queued normally.
- **Asynchronous reset mid-operation:** returns everything to reset values immediately. An in-flight command is abandoned with no done expected.

## Timing
- Trigger at cycle t: pending visible at t+1, o_cmd_valid at t+2 when the block is IDLE.
- Handshake at cycle h: o_cmd_valid=0 and the pending bit cleared at h+1.
- Done at cycle d: IDLE at d+1, next o_cmd_valid at d+2 at the earliest.
- Minimum issue interval with ready and done tied high: 3 cycles (ISSUE, WAIT_DONE, IDLE).
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package rggen_trigger_scheduler_pkg holds the state enum (IDLE, ISSUE, WAIT_DONE) only.
- Sub-module rggen_round_robin_picker: combinational. Takes request and pointer, produces found and index. Kept separate so other controllers can reuse it.

## Test plan
- **Single trigger:** WIDTH=4, pulse i_trigger=4'b0100 at t, ready tied high -> o_pending[2]=1 at t+1, o_cmd_valid with index 2 at t+2, pending cleared at t+3, o_busy until the cycle after done.
- **Round robin:** i_trigger=4'b1011 in one cycle, ready and done tied high -> grant order 0, 1, 3. Then a second 4'b1011 -> order 0, 1, 3 again, since the pointer ends at 3.
- **Backpressure:** ready held low 5 cycles after valid -> valid and index stable for all 5 cycles. A new trigger on another source during the stall does not change the index.
- **Overrun:** trigger source 1 twice while stalled in ISSUE on source 0 -> o_overrun[1]=1. Clear and a new overrun in the same cycle -> o_overrun[1] stays 1. A clear alone -> 0.
- **Trigger coinciding with handshake clear:** trigger source 2 in the same cycle as source 2's handshake -> pending[2] stays 1, o_overrun[2]=0, source 2 issued again after done.
- **Reset in WAIT_DONE with pending 4'b0110:** all outputs return to reset values. A done asserted after reset is ignored, and no command is issued.

Source files
------------

// File: rtl/rggen_trigger_scheduler_pkg.sv
// rggen_trigger_scheduler_pkg
// Shared definitions for the trigger scheduler: the controller state encoding.
package rggen_trigger_scheduler_pkg;

  // IDLE: looking for a pending request; ISSUE: command offered, waiting for
  // ready; WAIT_DONE: command accepted, waiting for the completion strobe.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rggen_trigger_scheduler_if.sv
// rggen_trigger_scheduler_if
// Downstream command channel of the trigger scheduler.
//   cmd_valid : scheduler -> engine, a command is offered
//   cmd_index : scheduler -> engine, source index of the offered command
//   cmd_ready : engine -> scheduler, command accepted this cycle
//   cmd_done  : engine -> scheduler, accepted command has finished
// master = scheduler side, slave = engine side.
interface rggen_trigger_scheduler_if #(
  parameter int INDEX_WIDTH = 2
) ();

  logic                   cmd_valid;
  logic [INDEX_WIDTH-1:0] cmd_index;
  logic                   cmd_ready;
  logic                   cmd_done;

  modport master (
    output cmd_valid,
    output cmd_index,
    input  cmd_ready,
    input  cmd_done
  );

  modport slave (
    input  cmd_valid,
    input  cmd_index,
    output cmd_ready,
    output cmd_done
  );

endinterface

// File: rtl/rggen_round_robin_picker.sv
// rggen_round_robin_picker
// Combinational round-robin search: finds the first set bit of request,
// starting at pointer+1 and wrapping around, so the last grantee (pointer)
// has the lowest priority.
//   request : WIDTH-bit request vector
//   pointer : index of the most recent grant
//   found   : at least one request bit is set
//   index   : index of the selected request (0 when found is low)
module rggen_round_robin_picker #(
  parameter int WIDTH       = 4,
  parameter int INDEX_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]       request,
  input  logic [INDEX_WIDTH-1:0] pointer,
  output logic                   found,
  output logic [INDEX_WIDTH-1:0] index
);

  int pos;

  // Walk offsets from farthest to nearest so the nearest set bit after the
  // pointer is the last one written and therefore wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    pos   = 0;
    for (int off = WIDTH; off >= 1; off--) begin
      pos   = (int'(pointer) + off) % WIDTH;
      found = found | request[pos];
      index = request[pos] ? INDEX_WIDTH'(pos) : index;
    end
  end

endmodule

// File: rtl/rggen_trigger_scheduler.sv
// rggen_trigger_scheduler
// Latches one-cycle trigger pulses as pending requests, grants them
// round-robin and issues one command at a time on the command channel,
// waiting for the completion strobe before issuing the next.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_trigger        : per-source trigger pulses
//   o_pending        : latched requests not yet accepted downstream
//   o_overrun        : sticky, a trigger hit an already pending source
//   i_overrun_clear  : per-bit clear of o_overrun
//   cmd_if           : command channel (valid/index/ready/done)
//   o_busy           : controller is not IDLE
// All outputs are registered.
module rggen_trigger_scheduler
  import rggen_trigger_scheduler_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [WIDTH-1:0]             i_trigger,
  output logic [WIDTH-1:0]             o_pending,
  output logic [WIDTH-1:0]             o_overrun,
  input  logic [WIDTH-1:0]             i_overrun_clear,
  rggen_trigger_scheduler_if.master    cmd_if,
  output logic                         o_busy
);

  localparam int INDEX_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e                 state;
  state_e                 state_next;
  logic [INDEX_WIDTH-1:0] pointer;
  logic [INDEX_WIDTH-1:0] pointer_next;
  logic [INDEX_WIDTH-1:0] index_next;
  logic                   valid_next;
  logic                   pick_found;
  logic [INDEX_WIDTH-1:0] pick_index;
  logic                   handshake;
  logic [WIDTH-1:0]       clear_mask;
  logic [WIDTH-1:0]       pending_next;
  logic [WIDTH-1:0]       overrun_next;

  rggen_round_robin_picker #(
    .WIDTH       (WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_picker (
    .request (o_pending),
    .pointer (pointer),
    .found   (pick_found),
    .index   (pick_index)
  );

  // Ready only counts while a command is actually offered.
  assign handshake = cmd_if.cmd_valid & cmd_if.cmd_ready;

  // One-hot mask of the pending bit being retired by this cycle's handshake.
  always_comb begin
    clear_mask = '0;
    for (int k = 0; k < WIDTH; k++) begin
      clear_mask[k] = handshake && (cmd_if.cmd_index == INDEX_WIDTH'(k));
    end
  end

  // A trigger always wins over the handshake clear; it only counts as an
  // overrun when the bit stays pending without being retired this cycle.
  always_comb begin
    pending_next = (o_pending & ~clear_mask) | i_trigger;
    overrun_next = (o_overrun & ~i_overrun_clear)
                 | (i_trigger & o_pending & ~clear_mask);
  end

  // Controller next-state and command-channel next values.
  always_comb begin
    state_next   = state;
    pointer_next = pointer;
    index_next   = cmd_if.cmd_index;
    valid_next   = cmd_if.cmd_valid;
    case (state)
      IDLE: begin
        if (pick_found) begin
          index_next = pick_index;
          valid_next = 1'b1;
          state_next = ISSUE;
        end else begin
          valid_next = 1'b0;
        end
      end
      ISSUE: begin
        if (cmd_if.cmd_ready) begin
          valid_next   = 1'b0;
          pointer_next = cmd_if.cmd_index;
          state_next   = WAIT_DONE;
        end else begin
          valid_next = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (cmd_if.cmd_done) begin
          state_next = IDLE;
        end else begin
          state_next = WAIT_DONE;
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  // State, pointer and all registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= IDLE;
      pointer          <= INDEX_WIDTH'(WIDTH - 1);
      o_pending        <= '0;
      o_overrun        <= '0;
      cmd_if.cmd_valid <= 1'b0;
      cmd_if.cmd_index <= '0;
      o_busy           <= 1'b0;
    end else begin
      state            <= state_next;
      pointer          <= pointer_next;
      o_pending        <= pending_next;
      o_overrun        <= overrun_next;
      cmd_if.cmd_valid <= valid_next;
      cmd_if.cmd_index <= index_next;
      o_busy           <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_rggen_trigger_scheduler.sv
// tb_rggen_trigger_scheduler
// Directed stimulus with a scoreboard: each expected grant is queued when
// the stimulus is issued; a monitor pops and compares on every handshake.
module tb_rggen_trigger_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] trigger;
  logic [3:0] overrun_clear;
  logic [3:0] pending;
  logic [3:0] overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int exp_idx;

  rggen_trigger_scheduler_if #(.INDEX_WIDTH(2)) cmd_if ();

  rggen_trigger_scheduler #(.WIDTH(4)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_trigger       (trigger),
    .o_pending       (pending),
    .o_overrun       (overrun),
    .i_overrun_clear (overrun_clear),
    .cmd_if          (cmd_if),
    .o_busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (!busy && !cmd_if.cmd_valid && pending == 4'd0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check({name, "_idle"}, 32'(ok), 32'd1);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor: compare the granted index on every handshake.
  always @(negedge clk) begin
    if (rst_n && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmd actual=%0d required=none", cmd_if.cmd_index);
      end else begin
        exp_idx = exp_q.pop_front();
        check("cmd_index", 32'(cmd_if.cmd_index), 32'(exp_idx));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n            = 1'b0;
    trigger          = 4'd0;
    overrun_clear    = 4'd0;
    cmd_if.cmd_ready = 1'b0;
    cmd_if.cmd_done  = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset values
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_valid", 32'(cmd_if.cmd_valid), 32'd0);
    check("rst_index", 32'(cmd_if.cmd_index), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Round robin from the reset pointer, twice
    cmd_if.cmd_ready = 1'b1;
    cmd_if.cmd_done  = 1'b1;
    for (int r = 0; r < 2; r++) begin
      trigger = 4'b1011;
      exp_q.push_back(0);
      exp_q.push_back(1);
      exp_q.push_back(3);
      tick();
      trigger = 4'd0;
      check("rr_pending", 32'(pending), 32'hb);
      wait_idle("rr");
    end

    // Single trigger on source 2
    cmd_if.cmd_done = 1'b0;
    trigger = 4'b0100;
    exp_q.push_back(2);
    tick();
    trigger = 4'd0;
    check("single_pending_t1", 32'(pending), 32'h4);
    check("single_valid_t1", 32'(cmd_if.cmd_valid), 32'd0);
    tick();
    check("single_valid_t2", 32'(cmd_if.cmd_valid), 32'd1);
    check("single_index_t2", 32'(cmd_if.cmd_index), 32'd2);
    check("single_busy_t2", 32'(busy), 32'd1);
    tick();
    check("single_valid_t3", 32'(cmd_if.cmd_valid), 32'd0);
    check("single_pending_t3", 32'(pending), 32'd0);
    check("single_busy_t3", 32'(busy), 32'd1);
    tick();
    check("single_busy_wait", 32'(busy), 32'd1);
    cmd_if.cmd_done = 1'b1;
    tick();
    check("single_busy_done", 32'(busy), 32'd0);

    // Backpressure on source 0 with overruns on source 1
    cmd_if.cmd_ready = 1'b0;
    trigger = 4'b0001;
    exp_q.push_back(0);
    tick();
    trigger = 4'd0;
    tick();
    check("bp_valid_start", 32'(cmd_if.cmd_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        trigger = 4'b0010;
        exp_q.push_back(1);
      end else if (i == 2) begin
        trigger = 4'b0010;
      end else begin
        trigger = 4'd0;
      end
      tick();
      trigger = 4'd0;
      check("bp_valid_hold", 32'(cmd_if.cmd_valid), 32'd1);
      check("bp_index_hold", 32'(cmd_if.cmd_index), 32'd0);
    end
    check("ovr_set", 32'(overrun), 32'h2);
    overrun_clear = 4'b0010;
    trigger       = 4'b0010;
    tick();
    trigger = 4'd0;
    check("ovr_set_wins", 32'(overrun), 32'h2);
    tick();
    overrun_clear = 4'd0;
    check("ovr_cleared", 32'(overrun), 32'd0);
    cmd_if.cmd_ready = 1'b1;
    wait_idle("bp");

    // Trigger coinciding with its own handshake clear
    cmd_if.cmd_ready = 1'b0;
    cmd_if.cmd_done  = 1'b0;
    trigger = 4'b0100;
    exp_q.push_back(2);
    tick();
    trigger = 4'd0;
    tick();
    check("coin_valid", 32'(cmd_if.cmd_valid), 32'd1);
    cmd_if.cmd_ready = 1'b1;
    trigger          = 4'b0100;
    tick();
    trigger          = 4'd0;
    cmd_if.cmd_ready = 1'b0;
    check("coin_pending", 32'(pending), 32'h4);
    check("coin_overrun", 32'(overrun), 32'd0);
    check("coin_valid_drop", 32'(cmd_if.cmd_valid), 32'd0);
    exp_q.push_back(2);
    cmd_if.cmd_done  = 1'b1;
    cmd_if.cmd_ready = 1'b1;
    wait_idle("coin");

    // Reset while in WAIT_DONE with pending 0110
    cmd_if.cmd_done = 1'b0;
    trigger = 4'b0010;
    exp_q.push_back(1);
    tick();
    trigger = 4'd0;
    tick();
    tick();
    trigger = 4'b0110;
    tick();
    trigger = 4'd0;
    check("mid_pending", 32'(pending), 32'h6);
    check("mid_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pending", 32'(pending), 32'd0);
    check("arst_overrun", 32'(overrun), 32'd0);
    check("arst_valid", 32'(cmd_if.cmd_valid), 32'd0);
    check("arst_index", 32'(cmd_if.cmd_index), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cmd_if.cmd_done = 1'b1;
    tick();
    cmd_if.cmd_done = 1'b0;
    repeat (10) tick();
    check("post_rst_valid", 32'(cmd_if.cmd_valid), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_pending", 32'(pending), 32'd0);
    check("post_rst_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
